// File: rtl/router_pkg.sv
// Shared router definitions: arbiter state encoding, default stream geometry
// and an elaboration-time ceil(log2) helper.
package router_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int N_REQ_DEFAULT        = 5;
    localparam int STREAM_WIDTH_DEFAULT = 132;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward with wrap-around. Returns a one-hot pick and its index.
module rr_pick
    import router_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int PTR_W = (clog2(N_REQ) > 0) ? clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PTR_W-1:0] idx
);

    logic [N_REQ-1:0] rot;
    logic             found;
    int               off;
    int               src;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        rot   = '0;
        found = 1'b0;
        off   = 0;
        src   = 0;
        pick  = '0;

        // Rotate so that bit 0 of rot is the request at ptr.
        for (int i = 0; i < N_REQ; i++) begin
            src = int'(ptr) + i;
            if (src >= N_REQ) src = src - N_REQ;
            rot[i] = req[src];
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = i;
            end
        end

        // Un-rotate the winning offset back into an input index.
        src = int'(ptr) + off;
        if (src >= N_REQ) src = src - N_REQ;
        idx = PTR_W'(src);
        if (found) pick[idx] = 1'b1;
    end

endmodule

// File: rtl/port_arbiter.sv
// Round-robin output-port arbiter holding one grant per packet.
// Optional burst split on MAX_BURST beats when PORT_ARB_BURST_LIMIT_EN is defined.
module port_arbiter
    import router_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEFAULT,
    parameter int STREAM_WIDTH = STREAM_WIDTH_DEFAULT,
    parameter int MAX_BURST    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0]              last,
    input  logic [N_REQ*STREAM_WIDTH-1:0] in_data,
    output logic [N_REQ-1:0]              grant,
    output logic                          out_valid,
    output logic [STREAM_WIDTH-1:0]       out_data,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int PTR_W = (clog2(N_REQ) > 0) ? clog2(N_REQ) : 1;

    arb_state_t       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick;
    logic             xfer;
    logic             g_last;
    logic             burst_hit;
    logic             rel;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx)
    );

    // grant is all-zero outside BUSY, so masking with it gates both outputs.
    assign out_valid = |(req & grant);
    assign g_last    = |(last & grant);
    assign xfer      = out_valid & out_ready;
    assign rel       = xfer & (g_last | burst_hit);
    assign busy      = (state == BUSY);
    assign next_ptr  = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) out_data = out_data | in_data[i*STREAM_WIDTH +: STREAM_WIDTH];
        end
    end

`ifdef PORT_ARB_BURST_LIMIT_EN
    localparam int BEAT_W = clog2(MAX_BURST) + 1;

    logic [BEAT_W-1:0] beat;

    assign burst_hit = (BEAT_W'(beat + 1'b1) == BEAT_W'(MAX_BURST));

    always_ff @(posedge clk) begin
        if (rst || rel) beat <= '0;
        else if (xfer)  beat <= beat + 1'b1;
    end
`else
    assign burst_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gidx  <= '0;
            grant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= pick;
                        gidx  <= pick_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (rel) begin
                        grant <= '0;
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_port_arbiter.sv
// Self-checking bench for port_arbiter: a directed vector table plus
// hand-written stall, back-pressure, reset and optional burst-split sequences.
module tb_port_arbiter;

    localparam int N  = 5;
    localparam int SW = 132;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*SW-1:0] in_data;
    logic [N-1:0]    grant;
    logic            out_valid;
    logic [SW-1:0]   out_data;
    logic            out_ready;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    port_arbiter #(
        .N_REQ        (N),
        .STREAM_WIDTH (SW),
        .MAX_BURST    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .in_data   (in_data),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] last;
        logic         rdy;
        logic [N-1:0] g;
        logic         v;
        logic         b;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [SW-1:0] word(input int i);
        return {4'(i + 1), 128'hC0DE_0000_1111_2222_3333_4444_5555_0000 + 128'(i)};
    endfunction

    function automatic logic [SW-1:0] data_for(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) return word(i);
        end
        return '0;
    endfunction

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are already applied; let combinational outputs settle, then compare.
    task automatic expect_out(input string tag, input logic [N-1:0] g, input logic v, input logic b);
        #1;
        check({tag, " grant"},     SW'(grant),     SW'(g));
        check({tag, " out_valid"}, SW'(out_valid), SW'(v));
        check({tag, " busy"},      SW'(busy),      SW'(b));
        check({tag, " out_data"},  out_data,       data_for(g));
    endtask

    initial begin
        tbl[0]  = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0};
        tbl[1]  = '{5'b00100, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0};
        tbl[2]  = '{5'b00100, 5'b00000, 1'b1, 5'b00100, 1'b1, 1'b1};
        tbl[3]  = '{5'b00100, 5'b00000, 1'b1, 5'b00100, 1'b1, 1'b1};
        tbl[4]  = '{5'b00100, 5'b00100, 1'b1, 5'b00100, 1'b1, 1'b1};
        tbl[5]  = '{5'b11111, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0};
        tbl[6]  = '{5'b11111, 5'b11111, 1'b1, 5'b01000, 1'b1, 1'b1};
        tbl[7]  = '{5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0};
        tbl[8]  = '{5'b11111, 5'b11111, 1'b1, 5'b10000, 1'b1, 1'b1};
        tbl[9]  = '{5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0};
        tbl[10] = '{5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 1'b1};
        tbl[11] = '{5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0};
        tbl[12] = '{5'b11111, 5'b11111, 1'b1, 5'b00010, 1'b1, 1'b1};
        tbl[13] = '{5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0};
        tbl[14] = '{5'b11111, 5'b11111, 1'b1, 5'b00100, 1'b1, 1'b1};
        tbl[15] = '{5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 1'b0};
        tbl[16] = '{5'b11111, 5'b11111, 1'b1, 5'b01000, 1'b1, 1'b1};
        tbl[17] = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0};

        for (int i = 0; i < N; i++) in_data[i*SW +: SW] = word(i);
        rst       = 1'b1;
        req       = '0;
        last      = '0;
        out_ready = 1'b1;
        #1;
        tick();
        tick();
        rst = 1'b0;

        // Three-beat packet on input 2, then one-beat round-robin rotation.
        for (int i = 0; i < 18; i++) begin
            req       = tbl[i].req;
            last      = tbl[i].last;
            out_ready = tbl[i].rdy;
            expect_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].v, tbl[i].b);
            tick();
        end

        // Requester stall: input 1 drops req mid-packet while input 3 waits.
        req = 5'b00010; last = '0;
        expect_out("stall idle", 5'b00000, 1'b0, 1'b0);
        tick();
        req = 5'b01010;
        expect_out("stall beat0", 5'b00010, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            req = 5'b01000;
            expect_out($sformatf("stall gap%0d", i), 5'b00010, 1'b0, 1'b1);
            tick();
        end
        req = 5'b01010; last = 5'b00010;
        expect_out("stall last", 5'b00010, 1'b1, 1'b1);
        tick();
        req = 5'b01000; last = '0;
        expect_out("stall bubble", 5'b00000, 1'b0, 1'b0);
        tick();
        expect_out("stall next", 5'b01000, 1'b1, 1'b1);
        last = 5'b01000;
        tick();
        req = '0; last = '0;
        expect_out("stall done", 5'b00000, 1'b0, 1'b0);
        tick();

        // Back-pressure during beat 1: state and word must hold.
        req = 5'b00001;
        expect_out("bp idle", 5'b00000, 1'b0, 1'b0);
        tick();
        expect_out("bp beat0", 5'b00001, 1'b1, 1'b1);
        tick();
        out_ready = 1'b0; last = 5'b00001;
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("bp hold%0d", i), 5'b00001, 1'b1, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        expect_out("bp release", 5'b00001, 1'b1, 1'b1);
        tick();
        req = '0; last = '0;
        expect_out("bp done", 5'b00000, 1'b0, 1'b0);
        tick();

        // Reset mid-packet: ptr is 1 here, so input 2 wins; reset must clear ptr.
        req = 5'b00100;
        tick();
        expect_out("rst beat0", 5'b00100, 1'b1, 1'b1);
        tick();
        expect_out("rst beat1", 5'b00100, 1'b1, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 5'b11111;
        expect_out("rst cleared", 5'b00000, 1'b0, 1'b0);
        tick();
        expect_out("rst regrant", 5'b00001, 1'b1, 1'b1);
        last = 5'b11111;
        tick();
        req = '0; last = '0;
        expect_out("rst done", 5'b00000, 1'b0, 1'b0);
        tick();

`ifdef PORT_ARB_BURST_LIMIT_EN
        // 10-beat packet on input 0 is split after 4 beats; input 2 gets a turn.
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 5'b00101; last = '0;
        expect_out("burst idle", 5'b00000, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("burst beat%0d", i), 5'b00001, 1'b1, 1'b1);
            tick();
        end
        expect_out("burst split", 5'b00000, 1'b0, 1'b0);
        tick();
        last = 5'b00100;
        expect_out("burst other", 5'b00100, 1'b1, 1'b1);
        tick();
        req = 5'b00001; last = '0;
        expect_out("burst bubble", 5'b00000, 1'b0, 1'b0);
        tick();
        expect_out("burst resume", 5'b00001, 1'b1, 1'b1);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
